// File: rtl/passcode_pkg.sv
// Shared types and helpers for the passcode checker: FSM states, default sizes
// and the expected-digit lookup into the packed code word.
package passcode_pkg;

    typedef enum logic [1:0] {
        ENTRY,
        UNLOCKED,
        LOCKOUT
    } state_t;

    localparam int DEFAULT_DIGIT_W  = 4;
    localparam int DEFAULT_CODE_LEN = 4;

    // Upper bounds for the generic slice helper; codes up to 256 bits, digits up to 32 bits.
    localparam int MAX_CODE_BITS = 256;
    localparam int MAX_DIGIT_W   = 32;

    // Digit k of the code, where digit 0 is the most significant (first entered) digit.
    function automatic logic [MAX_DIGIT_W-1:0] code_slice(
        input logic [MAX_CODE_BITS-1:0] code,
        input int                       code_len,
        input int                       digit_w,
        input int                       k
    );
        logic [MAX_CODE_BITS-1:0] shifted;
        logic [MAX_CODE_BITS-1:0] mask;
        shifted = code >> ((code_len - 1 - k) * digit_w);
        mask    = (MAX_CODE_BITS'(1) << digit_w) - MAX_CODE_BITS'(1);
        return MAX_DIGIT_W'(shifted & mask);
    endfunction

endpackage

// File: rtl/passcode_if.sv
// Digit strobe in, lock status out: the link between the button pulse
// generators (master) and the passcode checker (slave).
interface passcode_if
    import passcode_pkg::*;
#(
    parameter int DIGIT_W   = DEFAULT_DIGIT_W,
    parameter int CODE_LEN  = DEFAULT_CODE_LEN,
    parameter int MAX_TRIES = 3
) ();

    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);

    logic               digit_pulse;
    logic [DIGIT_W-1:0] digit;
    logic               unlocked;
    logic               locked_out;
    logic               fail_pulse;
    logic [CNT_W-1:0]   digit_cnt;
    logic [FAIL_W-1:0]  fail_cnt;

    modport master (
        output digit_pulse, digit,
        input  unlocked, locked_out, fail_pulse, digit_cnt, fail_cnt
    );

    modport slave (
        input  digit_pulse, digit,
        output unlocked, locked_out, fail_pulse, digit_cnt, fail_cnt
    );

endinterface

// File: rtl/cycle_timer.sv
// Up-counter with a synchronous clear that stops at a programmable terminal
// count; shared by the unlock window and the lockout period.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             clear,
    input  logic             run,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Holds at the terminal count so it can never wrap between uses.
    always_ff @(posedge clk) begin
        if (clr || clear) begin
            count <= '0;
        end else if (run && !done) begin
            count <= count + WIDTH'(1);
        end
    end

    assign done = (count == limit);

endmodule

// File: rtl/passcode_checker.sv
// Compares a stream of digit strobes against a fixed code on the fly and
// drives an unlock window, failure pulses and a timed lockout.
module passcode_checker
    import passcode_pkg::*;
#(
    parameter int                            CODE_LEN       = DEFAULT_CODE_LEN,
    parameter int                            DIGIT_W        = DEFAULT_DIGIT_W,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   CODE           = 16'h1234,
    parameter int                            MAX_TRIES      = 3,
    parameter int                            UNLOCK_CYCLES  = 100_000_000,
    parameter int                            LOCKOUT_CYCLES = 500_000_000
) (
    input logic       clk,
    input logic       clr,
    passcode_if.slave bus
);

    localparam int CNT_W     = $clog2(CODE_LEN + 1);
    localparam int FAIL_W    = $clog2(MAX_TRIES + 1);
    localparam int TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [CNT_W-1:0]   LAST_DIGIT    = CNT_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0]  LAST_TRY      = FAIL_W'(MAX_TRIES - 1);
    localparam logic [FAIL_W-1:0]  TRIES_MAXED   = FAIL_W'(MAX_TRIES);
    localparam logic [TIMER_W-1:0] UNLOCK_LIMIT  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LIMIT = TIMER_W'(LOCKOUT_CYCLES - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   digit_cnt, digit_cnt_next;
    logic [FAIL_W-1:0]  fail_cnt, fail_cnt_next;
    logic               mismatch, mismatch_next;
    logic               unlocked, locked_out, fail_pulse, fail_next;
    logic               digit_bad;
    logic [DIGIT_W-1:0] expected_digit;
    logic               timer_clear, timer_done;
    logic [TIMER_W-1:0] timer_limit;

    assign expected_digit = DIGIT_W'(code_slice(MAX_CODE_BITS'(CODE), CODE_LEN, DIGIT_W, int'(digit_cnt)));
    assign timer_limit    = (state == LOCKOUT) ? LOCKOUT_LIMIT : UNLOCK_LIMIT;

    cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk   (clk),
        .clr   (clr),
        .clear (timer_clear),
        .run   (state != ENTRY),
        .limit (timer_limit),
        .done  (timer_done)
    );

    // State register; the status outputs are registered alongside it from the next-state decode.
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= ENTRY;
            digit_cnt  <= '0;
            fail_cnt   <= '0;
            mismatch   <= 1'b0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
            fail_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            digit_cnt  <= digit_cnt_next;
            fail_cnt   <= fail_cnt_next;
            mismatch   <= mismatch_next;
            unlocked   <= (state_next == UNLOCKED);
            locked_out <= (state_next == LOCKOUT);
            fail_pulse <= fail_next;
        end
    end

    // Digits are only accepted in ENTRY; the timed states ignore strobes entirely.
    always_comb begin
        state_next     = state;
        digit_cnt_next = digit_cnt;
        fail_cnt_next  = fail_cnt;
        mismatch_next  = mismatch;
        fail_next      = 1'b0;
        timer_clear    = 1'b0;
        digit_bad      = (bus.digit != expected_digit);

        case (state)
            ENTRY: begin
                if (bus.digit_pulse) begin
                    if (digit_cnt < LAST_DIGIT) begin
                        digit_cnt_next = digit_cnt + CNT_W'(1);
                        mismatch_next  = mismatch | digit_bad;
                    end else begin
                        digit_cnt_next = '0;
                        mismatch_next  = 1'b0;
                        if (!(mismatch | digit_bad)) begin
                            state_next    = UNLOCKED;
                            fail_cnt_next = '0;
                            timer_clear   = 1'b1;
                        end else if (fail_cnt < LAST_TRY) begin
                            fail_cnt_next = fail_cnt + FAIL_W'(1);
                            fail_next     = 1'b1;
                        end else begin
                            state_next    = LOCKOUT;
                            fail_cnt_next = TRIES_MAXED;
                            fail_next     = 1'b1;
                            timer_clear   = 1'b1;
                        end
                    end
                end
            end
            UNLOCKED: begin
                if (timer_done) begin
                    state_next = ENTRY;
                end
            end
            LOCKOUT: begin
                if (timer_done) begin
                    state_next    = ENTRY;
                    fail_cnt_next = '0;
                end
            end
            default: begin
                state_next = ENTRY;
            end
        endcase
    end

    assign bus.unlocked   = unlocked;
    assign bus.locked_out = locked_out;
    assign bus.fail_pulse = fail_pulse;
    assign bus.digit_cnt  = digit_cnt;
    assign bus.fail_cnt   = fail_cnt;

endmodule
